// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_target_state_t;

    localparam int   C_BYTE_LEN = 8;
    localparam logic ACK        = 1'b0;
    localparam logic NACK       = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and bus event detector (START, STOP, SCL rise/fall).
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter per line.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int SS = (C_SYNC_STAGES < 2) ? 2 : C_SYNC_STAGES;

    logic [SS-1:0] scl_sync_q;
    logic [SS-1:0] sda_sync_q;
    logic          scl_s;
    logic          sda_s;
    logic          scl_l;
    logic          sda_l;
    logic          scl_prev_q;
    logic          sda_prev_q;

    // Lines reset to the idle (released) level so reset never fakes a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SS-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SS-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[SS-1];
    assign sda_s = sda_sync_q[SS-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_win_q;
    logic [1:0] sda_win_q;
    logic       scl_flt_q;
    logic       sda_flt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_win_q <= '1;
            sda_win_q <= '1;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_win_q <= {scl_win_q[0], scl_s};
            sda_win_q <= {sda_win_q[0], sda_s};
            scl_flt_q <= maj3(scl_s, scl_win_q[0], scl_win_q[1]);
            sda_flt_q <= maj3(sda_s, sda_win_q[0], sda_win_q[1]);
        end
    end

    assign scl_l = scl_flt_q;
    assign sda_l = sda_flt_q;
`else
    assign scl_l = scl_s;
    assign sda_l = sda_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_l;
            sda_prev_q <= sda_l;
        end
    end

    assign sda_o   = sda_l;
    assign start_o = scl_l & scl_prev_q & sda_prev_q & ~sda_l;
    assign stop_o  = scl_l & scl_prev_q & ~sda_prev_q & sda_l;
    assign rise_o  = scl_l & ~scl_prev_q;
    assign fall_o  = ~scl_l & scl_prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, pointer + data writes, reads from the pointer.
// Optional SCL/SDA glitch filter via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] C_ADDR        = 7'h1A,
    parameter int         C_NUM_REGS    = 16,
    parameter int         C_SYNC_STAGES = 2,
    localparam int        PW            = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_en,
    output logic [PW-1:0]     wr_addr,
    output logic [7:0]        wr_data,
    output logic [PW-1:0]     rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output i2c_target_state_t dbg_state
);

    localparam logic [PW-1:0] LAST_PTR = PW'(C_NUM_REGS - 1);
    localparam logic [3:0]    LAST_BIT = 4'(C_BYTE_LEN - 1);
    localparam logic [3:0]    BYTE_CNT = 4'(C_BYTE_LEN);

    i2c_target_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic          wr_en_q, wr_en_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          ack_inc_q, ack_inc_d;

    logic          sda_s;
    logic          ev_start;
    logic          ev_stop;
    logic          ev_rise;
    logic          ev_fall;
    logic [7:0]    rx_byte;
    logic [PW-1:0] ptr_next;

    i2c_bus_sync #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl),
        .sda_i  (sda),
        .sda_o  (sda_s),
        .start_o(ev_start),
        .stop_o (ev_stop),
        .rise_o (ev_rise),
        .fall_o (ev_fall)
    );

    // Open drain: the output enable clears asynchronously on reset.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign rx_byte  = {shift_q, sda_s};
    assign ptr_next = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ack_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ack_inc_q <= ack_inc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ack_inc_d = 1'b0;

        // Pointer advances the cycle after a written byte or a sampled read ACK.
        if (wr_en_q || ack_inc_q) begin
            ptr_d = ptr_next;
        end

        if (ev_start) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (ev_stop) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (ev_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = '0;
                            if (rx_byte[7:1] == C_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // The output enable doubles as the phase flag: first fall drives, second releases.
                ST_ADDR_ACK: begin
                    if (ev_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            state_d  = ST_RDATA;
                            cnt_d    = '0;
                            shift_d  = rd_data[6:0];
                            sda_oe_d = ~rd_data[7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR: begin
                    if (ev_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d   = '0;
                            ptr_d   = rx_byte[PW-1:0];
                            state_d = ST_PTR_ACK;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (ev_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (ev_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d     = '0;
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            state_d   = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    if (ev_rise && cnt_q != BYTE_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (ev_fall) begin
                        if (cnt_q == BYTE_CNT) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (ev_rise) begin
                        if (sda_s == ACK) begin
                            ack_inc_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (ev_fall) begin
                        state_d  = ST_RDATA;
                        cnt_d    = '0;
                        shift_d  = rd_data[6:0];
                        sda_oe_d = ~rd_data[7];
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = ptr_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C initiator plus a write scoreboard.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              scl = 1'b1;
    logic              host_sda = 1'b1;
    wire               sda_w;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [3:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    i2c_target_state_t dbg_state;

    logic [7:0]  regs [16];
    logic [11:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          tgt_low_cycles = 0;
    logic        busy_seen = 1'b0;

    pullup (sda_w);
    assign sda_w   = host_sda ? 1'bz : 1'b0;
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    i2c_target #(.C_ADDR(7'h1A), .C_NUM_REGS(16), .C_SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda_w),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scores every wr_en pulse against the expected queue, updates the register model.
    always @(negedge clk) begin
        logic [11:0] exp;
        if (!rst) begin
            if (host_sda && sda_w === 1'b0) tgt_low_cycles++;
            if (busy) busy_seen = 1'b1;
            if (wr_en) begin
                regs[wr_addr] = wr_data;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr %0d data 0x%02h, expected no write", wr_addr, wr_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp) begin
                        errors++;
                        $display("FAIL wr_pulse: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                                 wr_addr, wr_data, exp[11:8], exp[7:0]);
                    end
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        host_sda = 1'b1; wait_q();
        scl = 1'b1;      wait_q();
        host_sda = 1'b0; wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic bus_stop();
        host_sda = 1'b0; wait_q();
        scl = 1'b1;      wait_q();
        host_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        host_sda = b; wait_q();
        scl = 1'b1;   wait_q(); wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic write_bit_glitch(input logic b);
        host_sda = b; wait_q();
        scl = 1'b1;   wait_q();
        scl = 1'b0;   @(negedge clk);
        scl = 1'b1;   wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic read_bit(output logic b);
        host_sda = 1'b1; wait_q();
        scl = 1'b1;      wait_q();
        b = sda_w;       wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(ack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] ptr_bits;
        for (int i = 0; i < 16; i++) regs[i] = 8'h40 + 8'(i);

        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_sda", 32'(sda_w), 32'd1);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // Write: pointer 3, data A5, 5A
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5A});
        bus_start();
        write_byte(8'h34, ack); check("wr_addr_ack", 32'(ack), 32'(ACK));
        check("wr_busy_during", 32'(busy), 32'd1);
        write_byte(8'h03, ack); check("wr_ptr_ack", 32'(ack), 32'(ACK));
        write_byte(8'hA5, ack); check("wr_d0_ack", 32'(ack), 32'(ACK));
        write_byte(8'h5A, ack); check("wr_d1_ack", 32'(ack), 32'(ACK));
        bus_stop();
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_rd_addr", 32'(rd_addr), 32'd5);

        // Read with repeated START from pointer 15, wrapping to 0
        bus_start();
        write_byte(8'h34, ack); check("rd_addr_w_ack", 32'(ack), 32'(ACK));
        write_byte(8'h0F, ack); check("rd_ptr_ack", 32'(ack), 32'(ACK));
        bus_start();
        write_byte(8'h35, ack); check("rd_addr_r_ack", 32'(ack), 32'(ACK));
        read_byte(ACK, rd);  check("rd_byte0", 32'(rd), 32'h4F);
        read_byte(NACK, rd); check("rd_byte1", 32'(rd), 32'h40);
        check("rd_sda_released", 32'(sda_w), 32'd1);
        check("rd_state_ignore", 32'(dbg_state), 32'(ST_IGNORE));
        bus_stop();
        check("rd_busy_after_stop", 32'(busy), 32'd0);
        check("rd_ptr_wrapped", 32'(rd_addr), 32'd0);

        // Address mismatch
        tgt_low_cycles = 0;
        busy_seen = 1'b0;
        bus_start();
        write_byte(8'h36, ack); check("mm_addr_nack", 32'(ack), 32'(NACK));
        write_byte(8'h00, ack); check("mm_data_nack", 32'(ack), 32'(NACK));
        bus_stop();
        check("mm_sda_never_low", 32'(tgt_low_cycles), 32'd0);
        check("mm_busy_never", 32'(busy_seen), 32'd0);

        // Asynchronous reset while the target drives a 0 bit (regs[0] = 0x40, MSB 0)
        bus_start();
        write_byte(8'h35, ack); check("rst_addr_ack", 32'(ack), 32'(ACK));
        check("rst_sda_driven", 32'(sda_w), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_sda_async", 32'(sda_w), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back({4'd0, 8'h11});
        bus_start();
        write_byte(8'h34, ack); check("post_rst_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h00, ack); check("post_rst_ptr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h11, ack); check("post_rst_data_ack", 32'(ack), 32'(ACK));
        bus_stop();
        check("post_rst_rd_addr", 32'(rd_addr), 32'd1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // SCL glitch during the pointer byte must not count as a bit
        ptr_bits = 8'h02;
        bus_start();
        write_byte(8'h34, ack); check("gl_addr_ack", 32'(ack), 32'(ACK));
        for (int i = 7; i >= 0; i--) begin
            if (i == 5) write_bit_glitch(ptr_bits[i]);
            else        write_bit(ptr_bits[i]);
        end
        read_bit(ack); check("gl_ptr_ack", 32'(ack), 32'(ACK));
        bus_stop();
        check("gl_ptr_value", 32'(rd_addr), 32'd2);
`endif

        // STOP after four pointer bits
        ptr_bits = rd_addr;
        bus_start();
        write_byte(8'h34, ack); check("ms_addr_ack", 32'(ack), 32'(ACK));
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        bus_stop();
        check("ms_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("ms_ptr_unchanged", 32'(rd_addr), 32'(ptr_bits[3:0]));
        check("ms_busy", 32'(busy), 32'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
